// File: rtl/debug_clkgen.sv
// debug_clkgen: multi-channel divided-clock generator for the debug domain.
// All channels share one phase epoch, which is set by a one-cycle ALIGN pass.
// After that the channels count freely, and locked rises once the settle
// window has elapsed. Any legal configuration write re-aligns every channel.

// One output channel: holds its programmed config and a free-running phase counter.
module debug_clkgen_chan #(
  parameter int CNT_W     = 16,
  parameter int DEF_DIV   = 4,
  parameter int DEF_HIGH  = 2,
  parameter int DEF_PHASE = 0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             align,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
  input  logic [CNT_W-1:0] wr_phase,
  input  logic             wr_en,
  output logic             outclk
);
  logic [CNT_W-1:0] div, high, phase, cnt;
  logic             en;

  // Config registers, phase counter and registered output bit.
  // A write lands on the same edge the top decides to re-align, so the counter
  // picks up the new div/phase on the following ALIGN edge.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      div    <= CNT_W'(DEF_DIV);
      high   <= CNT_W'(DEF_HIGH);
      phase  <= CNT_W'(DEF_PHASE);
      en     <= 1'b1;
      cnt    <= '0;
      outclk <= 1'b0;
    end else begin
      if (align) begin
        // Start the counter "phase" cycles behind the epoch: div-phase mod div.
        cnt    <= (phase == '0) ? '0 : div - phase;
        outclk <= 1'b0;
      end else begin
        cnt    <= (cnt == div - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);
        outclk <= en && (cnt < high);
      end
      if (wr) begin
        div   <= wr_div;
        high  <= wr_high;
        phase <= wr_phase;
        en    <= wr_en;
      end
    end
  end
endmodule

module debug_clkgen #(
  parameter int NUM_CLOCKS  = 4,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 64,
  parameter int DEF_DIV     = 4,
  parameter int DEF_HIGH    = 2,
  parameter int DEF_PHASE   = 0,
  localparam int CH_W       = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [CNT_W-1:0]      cfg_div,
  input  logic [CNT_W-1:0]      cfg_high,
  input  logic [CNT_W-1:0]      cfg_phase,
  input  logic                  cfg_enable,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);
  localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {ALIGN, SETTLE, LOCKED} state_t;

  state_t                state, state_n;
  logic [LCK_W-1:0]      lcnt;
  logic                  accept, bad, wr_ok, align, settle_done;
  logic [NUM_CLOCKS-1:0] sel;

  // No writes while re-aligning or held in reset.
  assign cfg_ready   = rst && (state != ALIGN);
  assign accept      = cfg_valid && cfg_ready;
  assign bad         = (int'(cfg_chan) >= NUM_CLOCKS) || (cfg_div < CNT_W'(2)) ||
                       (cfg_phase >= cfg_div);
  assign wr_ok       = accept && !bad;
  assign align       = (state == ALIGN);
  assign settle_done = (state == SETTLE) && (lcnt == LCK_W'(LOCK_CYCLES - 1));

  // State register.
  always_ff @(posedge refclk) begin
    if (!rst) state <= ALIGN;
    else      state <= state_n;
  end

  // Next state: a legal write always wins and restarts alignment.
  always_comb begin
    state_n = state;
    case (state)
      ALIGN:   state_n = SETTLE;
      SETTLE:  if (wr_ok) state_n = ALIGN;
               else if (settle_done) state_n = LOCKED;
      LOCKED:  if (wr_ok) state_n = ALIGN;
      default: state_n = ALIGN;
    endcase
  end

  // Settle counter, lock flag and the reject pulse.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      lcnt    <= '0;
      locked  <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= accept && bad;
      if (align)                     lcnt <= '0;
      else if (state == SETTLE)      lcnt <= lcnt + LCK_W'(1);
      if (wr_ok)                     locked <= 1'b0;
      else if (settle_done)          locked <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
    assign sel[i] = wr_ok && (cfg_chan == CH_W'(i));

    debug_clkgen_chan #(
      .CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .DEF_HIGH(DEF_HIGH), .DEF_PHASE(DEF_PHASE)
    ) u_ch (
      .refclk   (refclk),
      .rst      (rst),
      .align    (align),
      .wr       (sel[i]),
      .wr_div   (cfg_div),
      .wr_high  (cfg_high),
      .wr_phase (cfg_phase),
      .wr_en    (cfg_enable),
      .outclk   (outclk[i])
    );
  end
endmodule

// File: doc/debug_clkgen.md
# debug_clkgen

Parametrised, fully synchronous multi-channel clock generator for the debug clock domain. It derives up to NUM_CLOCKS divided clock outputs from a single reference clock. Each channel has a runtime-programmable divide ratio, high time, phase offset and enable. All channels share a phase epoch, and a `locked` indication is raised after a fixed settle period. It sits where the fixed single-output debug PLL sat and feeds debug and capture logic that needs several related, phase-aligned slow clocks or strobes.

## Interface
- NUM_CLOCKS, 4: number of output channels, 1..16.
- CNT_W, 16: width of the divide, high and phase fields and of the per-channel counters.
- LOCK_CYCLES, 64: settle cycles after alignment before `locked` rises; must be ≥1.
- DEF_DIV, 4: reset divide ratio of every channel; must be ≥2.
- DEF_HIGH, 2: reset high time of every channel.
- DEF_PHASE, 0: reset phase of every channel; must be < DEF_DIV.

- refclk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready at a clock edge.
- cfg_chan  in  CH_W  target channel; CH_W = max(1, clog2(NUM_CLOCKS)).
- cfg_div  in  CNT_W  divide ratio (period in refclk cycles).
- cfg_high  in  CNT_W  cycles high per period.
- cfg_phase  in  CNT_W  delay of the channel relative to the epoch, in refclk cycles.
- cfg_enable  in  1  channel enable.
- cfg_err  out  1  one-cycle pulse: the accepted write was rejected.
- outclk  out  NUM_CLOCKS  registered divided clocks.
- locked  out  1  all channels are aligned and settled.

## Operation
**Per-channel registers**
- Each channel holds div, high, phase, en and cnt.
- Reset values: DEF_DIV, DEF_HIGH, DEF_PHASE, en=1, cnt=0.

**FSM states: ALIGN, SETTLE, LOCKED.** Reset enters ALIGN.
- **ALIGN** (exactly one cycle)
  - Every channel loads cnt = (phase==0) ? 0 : div−phase.
  - All outclk bits are set to 0.
  - The lock counter is cleared.
  - Next state is SETTLE.
- **SETTLE**
  - The lock counter increments every cycle.
  - When the counter equals LOCK_CYCLES−1, the FSM moves to LOCKED and `locked` is set to 1.
- **LOCKED**
  - The FSM holds until a legal write is accepted.

**Counting (SETTLE and LOCKED)**
- Each cycle: cnt ← (cnt==div−1) ? 0 : cnt+1.
- Each cycle: outclk[i] ← en && (cnt < high), using the current (pre-increment) cnt.
- high=0 gives constant 0; high ≥ div gives constant 1.
- A disabled channel outputs 0, but its counter keeps running.
- Arithmetic is unsigned CNT_W. phase < div is guaranteed for stored values, so div−phase never wraps.

**Configuration**
- cfg_ready = 1 in SETTLE and LOCKED; cfg_ready = 0 in ALIGN and during reset.
- A write is illegal if any of these holds: cfg_chan ≥ NUM_CLOCKS, cfg_div < 2, or cfg_phase ≥ cfg_div.
  - An illegal write is consumed without any register or state change.
  - cfg_err pulses high for one cycle.
- A legal write updates the target channel's registers.
  - The FSM goes to ALIGN.
  - `locked` clears on the same edge.
  - All channels re-align, not only the target channel.
- A legal write during SETTLE restarts alignment and the settle count.

**Reset**
- A reset asserted at any point overrides a simultaneous cfg write.
- All registers return to their reset values on that edge.

## Timing
- Values while rst=0: outclk=0, locked=0, cfg_ready=0, cfg_err=0, state=ALIGN.
- First edge with rst=1: ALIGN executes.
- `locked` rises after edge LOCK_CYCLES+1, counting from the first rst=1 edge as edge 1.
- Output latency: outclk reflects cnt one cycle later.
- After ALIGN, a phase-0 channel is high starting at the second edge.
- Legal write accepted at edge k:
  - `locked`=0 after edge k.
  - ALIGN runs at edge k+1 (outclk=0 after edge k+1).
  - `locked`=1 after edge k+1+LOCK_CYCLES.
- Illegal write accepted at edge k: cfg_err=1 after edge k and 0 after edge k+1. `locked` and outclk are undisturbed.
- Back-to-back writes:
  - A second write cannot be accepted in the ALIGN cycle.
  - The earliest next acceptance is edge k+2.

## Test plan
- Reset release with defaults (DIV=4, HIGH=2, PHASE=0, LOCK_CYCLES=64) -> every outclk bit reads 1,1,0,0 repeating, starting after edge 2; locked=1 after edge 65; cfg_ready=1 from edge 2.
- Write ch1 div=6, high=3, phase=2 while LOCKED -> locked drops next edge; after ALIGN, ch1 is 0,0 then 1,1,1,0,0,0 repeating; ch0 re-aligned to 1,1,0,0; locked returns 65 edges after acceptance.
- Illegal writes (div=1; phase=5 with div=5; chan=NUM_CLOCKS) -> one-cycle cfg_err each; locked stays 1; outclk waveforms unchanged.
- Edge cases: high=0 -> constant 0; high=7 with div=4 -> constant 1; cfg_enable=0 -> channel 0 while others keep toggling.
- rst driven low during SETTLE with cfg_valid=1 on the same edge -> write ignored; all defaults restored; lock sequence restarts from edge 1 after release.
- Second legal write 10 cycles after the first (during SETTLE) -> settle restarts; locked rises 65 edges after the second acceptance, not the first.
